// File: rtl/ctrl_sequencer_if.sv
// Shared-bus handshake between the instruction sequencer and the ALU/register-file datapath.
interface ctrl_sequencer_if #(
   parameter int WORD_W = 10,
   parameter int NREG   = 4
);
   logic              Start;
   logic [WORD_W-1:0] INSTR;
   logic              Ain;
   logic              Gin;
   logic              Gout;
   logic [3:0]        FN;
   logic [NREG-1:0]   ROUT;
   logic [NREG-1:0]   RIN;
   logic              Extern;
   logic              GSEL;
   logic              Busy;
   logic              Done;
   logic              Illegal;

   modport master (
      input  Start, INSTR,
      output Ain, Gin, Gout, FN, ROUT, RIN, Extern, GSEL, Busy, Done, Illegal
   );

   modport slave (
      output Start, INSTR,
      input  Ain, Gin, Gout, FN, ROUT, RIN, Extern, GSEL, Busy, Done, Illegal
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-step instruction sequencer: latches one instruction and walks T1..T4, driving
// registered ALU strobes, register one-hots and bus selects on the falling edge of CLKb.
module ctrl_sequencer #(
   parameter int WORD_W = 10,
   parameter int NREG   = 4
) (
   input  logic               CLKb,
   input  logic               RST,
   ctrl_sequencer_if.master   bus
);

   typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;
   typedef enum logic [2:0] {CL_LD, CL_CPY, CL_BIN, CL_UN, CL_ILL} opclass_t;

   state_t            state, state_nxt;
   logic [WORD_W-1:0] ir, ir_nxt;

   logic            ain_q, gin_q, gout_q, ext_q, gsel_q, busy_q, done_q, ill_q;
   logic [3:0]      fn_q;
   logic [NREG-1:0] rout_q, rin_q;

   logic            ain_n, gin_n, gout_n, ext_n, gsel_n, busy_n, done_n, ill_n;
   logic [3:0]      fn_n;
   logic [NREG-1:0] rout_n, rin_n;

   logic [3:0] op;
   logic [1:0] rx, ry;
   opclass_t   cls;
   logic       unused_ir_lo;

   function automatic opclass_t classify(input logic [3:0] opc);
      case (opc)
         4'b0000:                           return CL_LD;
         4'b0001:                           return CL_CPY;
         4'b0100, 4'b0101:                  return CL_UN;
         4'b1100, 4'b1101, 4'b1110, 4'b1111: return CL_ILL;
         default:                           return CL_BIN;
      endcase
   endfunction

   function automatic logic [NREG-1:0] onehot(input logic [1:0] idx);
      logic [NREG-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Outputs are decoded from the state being entered so they appear for exactly that step.
   always_comb begin
      state_nxt = state;
      ir_nxt    = ir;
      if (state == IDLE) begin
         if (bus.Start) begin
            state_nxt = T1;
            ir_nxt    = bus.INSTR;
         end
      end else if (done_q) begin
         state_nxt = IDLE;
      end else begin
         state_nxt = state_t'(state + 3'd1);
      end

      op  = ir_nxt[9:6];
      rx  = ir_nxt[5:4];
      ry  = ir_nxt[3:2];
      cls = classify(op);

      ain_n  = 1'b0;
      gin_n  = 1'b0;
      gout_n = 1'b0;
      ext_n  = 1'b0;
      gsel_n = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      ill_n  = 1'b0;
      fn_n   = 4'b0000;
      rout_n = '0;
      rin_n  = '0;

      if (state_nxt != IDLE) begin
         busy_n = 1'b1;
         fn_n   = op;
         case (cls)
            CL_LD: begin
               ext_n  = 1'b1;
               rin_n  = onehot(rx);
               done_n = 1'b1;
            end
            CL_CPY: begin
               rout_n = onehot(ry);
               rin_n  = onehot(rx);
               done_n = 1'b1;
            end
            CL_BIN: begin
               case (state_nxt)
                  T1: begin
                     rout_n = onehot(rx);
                     ain_n  = 1'b1;
                  end
                  T2: begin
                     rout_n = onehot(ry);
                     gin_n  = 1'b1;
                  end
                  T3: gout_n = 1'b1;
                  T4: begin
                     gsel_n = 1'b1;
                     rin_n  = onehot(rx);
                     done_n = 1'b1;
                  end
                  default: ;
               endcase
            end
            CL_UN: begin
               case (state_nxt)
                  T1: begin
                     rout_n = onehot(ry);
                     gin_n  = 1'b1;
                  end
                  T2: gout_n = 1'b1;
                  T3: begin
                     gsel_n = 1'b1;
                     rin_n  = onehot(rx);
                     done_n = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: begin
               done_n = 1'b1;
               ill_n  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(negedge CLKb) begin
      if (RST) begin
         state  <= IDLE;
         ir     <= '0;
         ain_q  <= 1'b0;
         gin_q  <= 1'b0;
         gout_q <= 1'b0;
         ext_q  <= 1'b0;
         gsel_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ill_q  <= 1'b0;
         fn_q   <= 4'b0000;
         rout_q <= '0;
         rin_q  <= '0;
      end else begin
         state  <= state_nxt;
         ir     <= ir_nxt;
         ain_q  <= ain_n;
         gin_q  <= gin_n;
         gout_q <= gout_n;
         ext_q  <= ext_n;
         gsel_q <= gsel_n;
         busy_q <= busy_n;
         done_q <= done_n;
         ill_q  <= ill_n;
         fn_q   <= fn_n;
         rout_q <= rout_n;
         rin_q  <= rin_n;
      end
   end

   assign bus.Ain     = ain_q;
   assign bus.Gin     = gin_q;
   assign bus.Gout    = gout_q;
   assign bus.FN      = fn_q;
   assign bus.ROUT    = rout_q;
   assign bus.RIN     = rin_q;
   assign bus.Extern  = ext_q;
   assign bus.GSEL    = gsel_q;
   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.Illegal = ill_q;

   assign unused_ir_lo = ^ir[1:0];

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed instructions push hand-computed per-step
// output vectors; a posedge monitor pops and compares them whenever the sequencer is busy.
module tb_ctrl_sequencer;

   logic CLKb;
   logic RST;

   ctrl_sequencer_if #(.WORD_W(10), .NREG(4)) bus ();

   ctrl_sequencer #(.WORD_W(10), .NREG(4)) dut (
      .CLKb (CLKb),
      .RST  (RST),
      .bus  (bus)
   );

   initial CLKb = 1'b1;
   always #5 CLKb = ~CLKb;

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;
   logic [19:0] expq[$];

   // {Ain,Gin,Gout,FN,ROUT,RIN,Extern,GSEL,Busy,Done,Illegal}
   function automatic logic [19:0] mk(input logic ain, gin, gout, input logic [3:0] fn,
                                      input logic [3:0] rout, rin,
                                      input logic ext, gsel, done, ill);
      return {ain, gin, gout, fn, rout, rin, ext, gsel, 1'b1, done, ill};
   endfunction

   function automatic logic [19:0] sample();
      return {bus.Ain, bus.Gin, bus.Gout, bus.FN, bus.ROUT, bus.RIN,
              bus.Extern, bus.GSEL, bus.Busy, bus.Done, bus.Illegal};
   endfunction

   always @(posedge CLKb) begin
      logic [19:0] act, exp_v;
      if (mon_en) begin
         act = sample();
         checks++;
         if (bus.Busy === 1'b1) begin
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_busy t=%0t got=%b required=idle", $time, act);
            end else begin
               exp_v = expq.pop_front();
               if (act !== exp_v) begin
                  errors++;
                  $display("FAIL step t=%0t got=%b required=%b", $time, act, exp_v);
               end
            end
         end else if (act !== 20'd0) begin
            errors++;
            $display("FAIL idle_outputs t=%0t got=%b required=%b", $time, act, 20'd0);
         end
      end
   end

   task automatic go(input logic [9:0] ins);
      @(posedge CLKb); #1;
      bus.Start = 1'b1;
      bus.INSTR = ins;
      @(posedge CLKb); #1;
      bus.Start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge CLKb); #1;
         if (bus.Busy === 1'b0 && expq.size() == 0) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_timeout busy=%b pending=%0d required busy=0 pending=0",
                  name, bus.Busy, expq.size());
         expq.delete();
      end
   endtask

   initial begin
      RST       = 1'b1;
      bus.Start = 1'b0;
      bus.INSTR = '0;
      repeat (2) @(posedge CLKb);
      #1;
      mon_en = 1;
      repeat (2) @(posedge CLKb);
      #1;
      RST = 1'b0;

      // ADD R1,R2
      expq.push_back(mk(1,0,0,4'b0010,4'b0010,4'b0000,0,0,0,0));
      expq.push_back(mk(0,1,0,4'b0010,4'b0100,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,1,4'b0010,4'b0000,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,0,4'b0010,4'b0000,4'b0010,0,1,1,0));
      go(10'b0010_01_10_00);
      wait_idle("add");

      // FLP R3,R0
      expq.push_back(mk(0,1,0,4'b0101,4'b0001,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,1,4'b0101,4'b0000,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,0,4'b0101,4'b0000,4'b1000,0,1,1,0));
      go(10'b0101_11_00_00);
      wait_idle("flp");

      // LD R2 with Start held through Done, then CPY R0,R2
      expq.push_back(mk(0,0,0,4'b0000,4'b0000,4'b0100,1,0,1,0));
      @(posedge CLKb); #1;
      bus.Start = 1'b1;
      bus.INSTR = 10'b0000_10_00_00;
      @(posedge CLKb); #1;
      bus.INSTR = 10'b0001_00_10_00;
      @(posedge CLKb); #1;
      bus.Start = 1'b0;
      expq.push_back(mk(0,0,0,4'b0001,4'b0100,4'b0001,0,0,1,0));
      go(10'b0001_00_10_00);
      wait_idle("ld_cpy");

      // Illegal opcode
      expq.push_back(mk(0,0,0,4'b1110,4'b0000,4'b0000,0,0,1,1));
      go(10'b1110_00_00_00);
      wait_idle("illegal");

      // SUB R2,R1 with a different Start/INSTR during T2
      expq.push_back(mk(1,0,0,4'b0011,4'b0100,4'b0000,0,0,0,0));
      expq.push_back(mk(0,1,0,4'b0011,4'b0010,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,1,4'b0011,4'b0000,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,0,4'b0011,4'b0000,4'b0100,0,1,1,0));
      go(10'b0011_10_01_00);
      @(posedge CLKb); #1;
      bus.Start = 1'b1;
      bus.INSTR = 10'b1110_00_00_00;
      @(posedge CLKb); #1;
      bus.Start = 1'b0;
      wait_idle("sub");

      // Rx == Ry binary op on R3
      expq.push_back(mk(1,0,0,4'b0110,4'b1000,4'b0000,0,0,0,0));
      expq.push_back(mk(0,1,0,4'b0110,4'b1000,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,1,4'b0110,4'b0000,4'b0000,0,0,0,0));
      expq.push_back(mk(0,0,0,4'b0110,4'b0000,4'b1000,0,1,1,0));
      go(10'b0110_11_11_00);
      wait_idle("same_reg");

      // Reset during T2 of ADD: only T1 and T2 may appear
      expq.push_back(mk(1,0,0,4'b0010,4'b0010,4'b0000,0,0,0,0));
      expq.push_back(mk(0,1,0,4'b0010,4'b0100,4'b0000,0,0,0,0));
      go(10'b0010_01_10_00);
      @(posedge CLKb); #1;
      RST = 1'b1;
      repeat (2) @(posedge CLKb);
      #1;
      RST = 1'b0;
      repeat (6) @(posedge CLKb);
      #1;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL reset_abort pending=%0d required=0", expq.size());
         expq.delete();
      end

      mon_en = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout t=%0t required=finish", $time);
      $fatal(1, "bench timeout");
   end

endmodule
